// File: rtl/sy_ppl_btb_upd.sv
// BTB update producer: filters correctly-predicted retire resolves, queues the
// rest in a small FIFO and issues at most one btb_update_t write per cycle.

package sy_ppl_btb_upd_pkg;
  localparam int AWTH = 32;

  typedef struct packed {
    logic            vld;
    logic [AWTH-1:0] pc;
    logic [AWTH-1:0] target_address;
  } btb_update_t;
endpackage

module sy_ppl_btb_upd
  import sy_ppl_btb_upd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WTH    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [1:0]          rs_vld_i,
  output logic                rs_rdy_o,
  input  logic [2*AWTH-1:0]   rs_pc_i,
  input  logic [2*AWTH-1:0]   rs_target_i,
  input  logic [1:0]          rs_is_cf_i,
  input  logic [1:0]          rs_taken_i,
  input  logic [1:0]          rs_pred_vld_i,
  input  logic [2*AWTH-1:0]   rs_pred_tgt_i,
  output btb_update_t         btb_update_o,
  output logic [CNT_WTH-1:0]  upd_cnt_o,
  output logic [CNT_WTH-1:0]  filt_cnt_o
);

  localparam int PTR_WTH = $clog2(FIFO_DEPTH);
  localparam logic [PTR_WTH:0] FREE_LIM = (PTR_WTH+1)'(FIFO_DEPTH - 2);

  // Saturating add of a 0..3 increment; counters stick at all-ones.
  function automatic logic [CNT_WTH-1:0] sat_add(input logic [CNT_WTH-1:0] a,
                                                 input logic [1:0]         inc);
    logic [CNT_WTH:0] sum;
    sum = {1'b0, a} + (CNT_WTH+1)'(inc);
    if (sum[CNT_WTH]) begin
      sat_add = {CNT_WTH{1'b1}};
    end else begin
      sat_add = sum[CNT_WTH-1:0];
    end
  endfunction

  logic [AWTH-1:0]    pc_mem_r  [FIFO_DEPTH];
  logic [AWTH-1:0]    tgt_mem_r [FIFO_DEPTH];
  logic [PTR_WTH-1:0] head_r;
  logic [PTR_WTH-1:0] tail_r;
  logic [PTR_WTH:0]   count_r;
  logic [CNT_WTH-1:0] upd_cnt_r;
  logic [CNT_WTH-1:0] filt_cnt_r;

  logic               rdy_s;
  logic               pop_s;
  logic [1:0]         acc_s;
  logic [1:0]         qual_s;
  logic [1:0]         push_s;
  logic               same_pc_s;
  logic [1:0]         n_push_s;
  logic [1:0]         filt_inc_s;
  logic [PTR_WTH-1:0] tail1_s;

  // Accept/qualify decode, same-pc collapse and FIFO pointer arithmetic.
  always_comb begin
    rdy_s      = 1'b0;
    pop_s      = 1'b0;
    acc_s      = 2'b00;
    qual_s     = 2'b00;
    push_s     = 2'b00;
    same_pc_s  = 1'b0;
    n_push_s   = 2'b00;
    filt_inc_s = 2'b00;
    tail1_s    = tail_r;

    rdy_s = rst_i & ~flush_i & (count_r <= FREE_LIM);
    pop_s = (count_r != (PTR_WTH+1)'(0)) & ~flush_i;

    for (int k = 0; k < 2; k++) begin
      acc_s[k]  = rs_vld_i[k] & rdy_s;
      qual_s[k] = rs_is_cf_i[k] & rs_taken_i[k] &
                  (~rs_pred_vld_i[k] |
                   (rs_pred_tgt_i[k*AWTH +: AWTH] != rs_target_i[k*AWTH +: AWTH]));
    end

    // Two updates to one pc in a cycle: the younger target wins.
    same_pc_s = acc_s[0] & qual_s[0] & acc_s[1] & qual_s[1] &
                (rs_pc_i[0 +: AWTH] == rs_pc_i[AWTH +: AWTH]);
    push_s[0] = acc_s[0] & qual_s[0] & ~same_pc_s;
    push_s[1] = acc_s[1] & qual_s[1];

    n_push_s   = {1'b0, push_s[0]} + {1'b0, push_s[1]};
    filt_inc_s = {1'b0, acc_s[0] & ~push_s[0]} + {1'b0, acc_s[1] & ~push_s[1]};
    tail1_s    = tail_r + PTR_WTH'(push_s[0]);
  end

  // Output drive: head entry straight out of the queue.
  always_comb begin
    btb_update_o                = '0;
    btb_update_o.vld            = pop_s;
    btb_update_o.pc             = pc_mem_r[head_r];
    btb_update_o.target_address = tgt_mem_r[head_r];
    rs_rdy_o                    = rdy_s;
    upd_cnt_o                   = upd_cnt_r;
    filt_cnt_o                  = filt_cnt_r;
  end

  // Queue pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_WTH'(pop_s);
      tail_r  <= tail_r + PTR_WTH'(n_push_s);
      count_r <= count_r + (PTR_WTH+1)'(n_push_s) - (PTR_WTH+1)'(pop_s);
    end
  end

  // Queue storage: port 0 lands at tail, port 1 right behind it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_r[i]  <= '0;
        tgt_mem_r[i] <= '0;
      end
    end else begin
      if (push_s[0]) begin
        pc_mem_r[tail_r]  <= rs_pc_i[0 +: AWTH];
        tgt_mem_r[tail_r] <= rs_target_i[0 +: AWTH];
      end
      if (push_s[1]) begin
        pc_mem_r[tail1_s]  <= rs_pc_i[AWTH +: AWTH];
        tgt_mem_r[tail1_s] <= rs_target_i[AWTH +: AWTH];
      end
    end
  end

  // Perf counters survive flush and only clear on reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      upd_cnt_r  <= '0;
      filt_cnt_r <= '0;
    end else begin
      upd_cnt_r  <= sat_add(upd_cnt_r, {1'b0, pop_s});
      filt_cnt_r <= sat_add(filt_cnt_r, filt_inc_s);
    end
  end

endmodule

// File: tb/tb_sy_ppl_btb_upd.sv
// Randomized bench for sy_ppl_btb_upd against a queue-based reference model.

module tb_sy_ppl_btb_upd;
  import sy_ppl_btb_upd_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int CMAX  = 255;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        vld   = 2'b00;
  logic [1:0]        is_cf = 2'b00;
  logic [1:0]        taken = 2'b00;
  logic [1:0]        pvld  = 2'b00;
  logic [31:0]       pc    [2];
  logic [31:0]       tgt   [2];
  logic [31:0]       ptgt  [2];
  logic              rs_rdy;
  btb_update_t       upd;
  logic [CW-1:0]     upd_cnt;
  logic [CW-1:0]     filt_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mq_pc  [$];
  logic [31:0] mq_tgt [$];
  int m_upd  = 0;
  int m_filt = 0;

  always #5 clk_i = ~clk_i;

  sy_ppl_btb_upd #(.FIFO_DEPTH(DEPTH), .CNT_WTH(CW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush),
    .rs_vld_i      (vld),
    .rs_rdy_o      (rs_rdy),
    .rs_pc_i       ({pc[1], pc[0]}),
    .rs_target_i   ({tgt[1], tgt[0]}),
    .rs_is_cf_i    (is_cf),
    .rs_taken_i    (taken),
    .rs_pred_vld_i (pvld),
    .rs_pred_tgt_i ({ptgt[1], ptgt[0]}),
    .btb_update_o  (upd),
    .upd_cnt_o     (upd_cnt),
    .filt_cnt_o    (filt_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle();
    flush = 1'b0;
    vld   = 2'b00;
    is_cf = 2'b00;
    taken = 2'b00;
    pvld  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      pc[k] = 32'h0; tgt[k] = 32'h0; ptgt[k] = 32'h0;
    end
  endtask

  task automatic set_port(input int k, input logic [31:0] p, input logic [31:0] t,
                          input logic cf, input logic tk, input logic pv,
                          input logic [31:0] pt);
    vld[k] = 1'b1; pc[k] = p; tgt[k] = t; is_cf[k] = cf; taken[k] = tk;
    pvld[k] = pv; ptgt[k] = pt;
  endtask

  // One clock: compare DUT against the model, advance the model, move to next negedge.
  task automatic cycle();
    bit e_rdy, e_vld;
    bit q[2];
    bit p0, p1;
    #1;
    e_rdy = !flush && (DEPTH - mq_pc.size() >= 2);
    e_vld = (mq_pc.size() != 0) && !flush;
    chk("rdy", 64'(rs_rdy), 64'(e_rdy));
    chk("vld", 64'(upd.vld), 64'(e_vld));
    if (e_vld) begin
      chk("pc",  64'(upd.pc), 64'(mq_pc[0]));
      chk("tgt", 64'(upd.target_address), 64'(mq_tgt[0]));
    end
    chk("upd_cnt",  64'(upd_cnt),  64'(m_upd));
    chk("filt_cnt", 64'(filt_cnt), 64'(m_filt));
    if (e_vld) begin
      void'(mq_pc.pop_front());
      void'(mq_tgt.pop_front());
      if (m_upd < CMAX) m_upd++;
    end
    if (e_rdy) begin
      for (int k = 0; k < 2; k++)
        q[k] = vld[k] && is_cf[k] && taken[k] && (!pvld[k] || ptgt[k] != tgt[k]);
      p1 = q[1];
      p0 = q[0] && !(q[1] && pc[0] == pc[1]);
      if (p0) begin mq_pc.push_back(pc[0]); mq_tgt.push_back(tgt[0]); end
      if (p1) begin mq_pc.push_back(pc[1]); mq_tgt.push_back(tgt[1]); end
      for (int k = 0; k < 2; k++)
        if (vld[k] && !(k == 0 ? p0 : p1) && m_filt < CMAX) m_filt++;
    end
    if (flush) begin
      mq_pc.delete();
      mq_tgt.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_tgt.delete();
    m_upd  = 0;
    m_filt = 0;
  endtask

  task automatic check_reset_state();
    #1;
    chk("rst_vld",  64'(upd.vld),  64'(0));
    chk("rst_rdy",  64'(rs_rdy),   64'(0));
    chk("rst_upd",  64'(upd_cnt),  64'(0));
    chk("rst_filt", 64'(filt_cnt), 64'(0));
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    #12;
    check_reset_state();
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;

    // Single mispredicted resolve appears one cycle later.
    set_port(0, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle();
    idle();
    chk("t1_vld", 64'(upd.vld), 64'(1));
    chk("t1_pc",  64'(upd.pc), 64'(32'h8000_0010));
    chk("t1_tgt", 64'(upd.target_address), 64'(32'h8000_0100));
    cycle();
    cycle();
    chk("t1_cnt", 64'(upd_cnt), 64'(1));

    // Correctly predicted resolve is filtered.
    set_port(0, 32'h8000_0020, 32'h8000_0200, 1'b1, 1'b1, 1'b1, 32'h8000_0200);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    chk("t2_filt", 64'(filt_cnt), 64'(1));

    // Dual qualifying resolves every cycle: backpressure and ordering.
    for (int i = 0; i < 10; i++) begin
      set_port(0, 32'h4000 + 32'(i * 8),     32'h9000 + 32'(i), 1'b1, 1'b1, 1'b0, 32'h0);
      set_port(1, 32'h4000 + 32'(i * 8 + 4), 32'hA000 + 32'(i), 1'b1, 1'b1, 1'b0, 32'h0);
      cycle();
    end
    idle();
    for (int i = 0; i < 5; i++) cycle();

    // Same pc on both ports: younger target only.
    set_port(0, 32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0);
    set_port(1, 32'h100, 32'h300, 1'b1, 1'b1, 1'b1, 32'h204);
    cycle();
    idle();
    chk("t4_tgt", 64'(upd.target_address), 64'(32'h300));
    cycle();
    chk("t4_vld", 64'(upd.vld), 64'(0));

    // Flush with three entries queued.
    set_port(0, 32'h500, 32'h600, 1'b1, 1'b1, 1'b0, 32'h0);
    set_port(1, 32'h504, 32'h604, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle();
    set_port(0, 32'h508, 32'h608, 1'b1, 1'b1, 1'b0, 32'h0);
    set_port(1, 32'h50c, 32'h60c, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle();
    idle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    set_port(1, 32'h700, 32'h800, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle();
    idle();
    chk("t5_pc", 64'(upd.pc), 64'(32'h700));
    cycle();

    // Async reset mid-stream with two queued.
    set_port(0, 32'hA00, 32'hB00, 1'b1, 1'b1, 1'b0, 32'h0);
    set_port(1, 32'hA04, 32'hB04, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle();
    idle();
    #2;
    rst_i = 1'b0;
    check_reset_state();
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic, long enough to saturate the 8-bit counters.
    for (int i = 0; i < 1500; i++) begin
      idle();
      flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 2; k++) begin
        vld[k]   = 1'($urandom_range(0, 3) != 0);
        pc[k]    = 32'h1000 + 32'($urandom_range(0, 3) * 4);
        tgt[k]   = 32'h2000 + 32'($urandom_range(0, 2) * 4);
        is_cf[k] = 1'($urandom_range(0, 3) != 0);
        taken[k] = 1'($urandom_range(0, 3) != 0);
        pvld[k]  = 1'($urandom_range(0, 1));
        ptgt[k]  = 32'h2000 + 32'($urandom_range(0, 2) * 4);
      end
      cycle();
    end
    idle();
    cycle();
    chk("sat_upd",  64'(upd_cnt),  64'(CMAX));
    chk("sat_filt", 64'(filt_cnt), 64'(CMAX));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
